apa102_read_arbiter: RTL and testbench

- Shares one 16-bit memory read port between two apa102_out LED channels (client A, client B).
- Each client presents a level read request and an address, and expects one read_finished_strobe with data per word.
- Sits between the per-channel read interfaces and the memory controller.
- Round-robin fairness, one outstanding memory read at a time, runs on the system clk.

---
 rtl/apa102_read_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_apa102_read_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apa102_read_arbiter
// Description : Round-robin arbiter that shares one 16-bit memory read port
//               between two apa102_out LED channels (client A and client B).
//               Only one memory read is in flight at a time. Each delivered
//               word is announced to its client with a one-cycle finished
//               strobe. A client that was just served sits out one cycle,
//               because its FIFO full flag lags the write strobe by one clk.
//               Optional feature macro: ARB_TIMEOUT_EN adds a WAIT watchdog.
//               If memory does not answer within TIMEOUT_CYCLES, the arbiter
//               delivers 16'hDEAD and sets a sticky timeout_error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module apa102_read_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  // client A
  input  logic                         a_read_request,
  input  logic [ADDRESS_BUS_WIDTH-1:0] a_read_address,
  output logic [15:0]                  a_read_data,
  output logic                         a_read_finished_strobe,
  // client B
  input  logic                         b_read_request,
  input  logic [ADDRESS_BUS_WIDTH-1:0] b_read_address,
  output logic [15:0]                  b_read_data,
  output logic                         b_read_finished_strobe,
  // memory controller
  output logic                         mem_read_start,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  input  logic [15:0]                  mem_read_data,
  input  logic                         mem_read_done,
  // status
  output logic                         busy,
  output logic [1:0]                   grant,
  output logic                         timeout_error
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  state_t                         r_state;
  logic                           r_last_grant;   // 0 = A, 1 = B
  logic                           r_holdoff_a;
  logic                           r_holdoff_b;
  logic [1:0]                     r_grant;
  logic                           r_busy;
  logic                           r_mem_read_start;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_mem_address;
  logic [15:0]                    r_a_data;
  logic [15:0]                    r_b_data;
  logic                           r_a_strobe;
  logic                           r_b_strobe;

  logic                           w_elig_a;
  logic                           w_elig_b;
  logic                           w_pick_b;
  logic                           w_capture;
  logic [15:0]                    w_capture_data;

  // A client sits out the cycle right after its own finished strobe.
  assign w_elig_a = a_read_request & ~r_holdoff_a;
  assign w_elig_b = b_read_request & ~r_holdoff_b;

  // B wins when it is the only eligible client, or on a tie after A was last.
  assign w_pick_b = w_elig_b & (~w_elig_a | ~r_last_grant);

`ifdef ARB_TIMEOUT_EN
  localparam int c_timer_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_timer_w-1:0] c_timeout_limit = c_timer_w'(TIMEOUT_CYCLES);

  logic [c_timer_w-1:0] r_timer;
  logic                 r_timeout_error;
  logic                 w_timeout_hit;

  // Watchdog expiry only counts when memory has not answered this cycle.
  assign w_timeout_hit  = (r_state == ST_WAIT) && !mem_read_done && (r_timer == c_timeout_limit);
  assign w_capture      = mem_read_done | w_timeout_hit;
  assign w_capture_data = mem_read_done ? mem_read_data : 16'hDEAD;
  assign timeout_error  = r_timeout_error;

  // WAIT-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer         <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == ST_WAIT && !w_capture) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_timeout_hit) begin
        r_timeout_error <= 1'b1;
      end
    end
  end
`else
  assign w_capture      = mem_read_done;
  assign w_capture_data = mem_read_data;
  assign timeout_error  = 1'b0;
`endif

  // Arbitration FSM with registered outputs: grant, issue, wait, deliver.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_last_grant     <= 1'b1;
      r_holdoff_a      <= 1'b0;
      r_holdoff_b      <= 1'b0;
      r_grant          <= 2'b00;
      r_busy           <= 1'b0;
      r_mem_read_start <= 1'b0;
      r_mem_address    <= '0;
      r_a_data         <= 16'h0000;
      r_b_data         <= 16'h0000;
      r_a_strobe       <= 1'b0;
      r_b_strobe       <= 1'b0;
    end else begin
      r_mem_read_start <= 1'b0;
      r_a_strobe       <= 1'b0;
      r_b_strobe       <= 1'b0;
      // The holdoff is simply the strobe delayed by one cycle.
      r_holdoff_a      <= r_a_strobe;
      r_holdoff_b      <= r_b_strobe;

      case (r_state)
        ST_IDLE: begin
          if (w_elig_a || w_elig_b) begin
            r_grant          <= w_pick_b ? 2'b10 : 2'b01;
            r_busy           <= 1'b1;
            r_last_grant     <= w_pick_b;
            r_mem_address    <= w_pick_b ? b_read_address : a_read_address;
            r_mem_read_start <= 1'b1;
            r_state          <= ST_ISSUE;
          end
        end

        // The start pulse is high during this state; a done here is ignored.
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (w_capture) begin
            if (r_grant[1]) begin
              r_b_data   <= w_capture_data;
              r_b_strobe <= 1'b1;
            end else begin
              r_a_data   <= w_capture_data;
              r_a_strobe <= 1'b1;
            end
            r_state <= ST_DELIVER;
          end
        end

        // Strobe is high during this state; release the port afterwards.
        ST_DELIVER: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_read_data            = r_a_data;
  assign b_read_data            = r_b_data;
  assign a_read_finished_strobe = r_a_strobe;
  assign b_read_finished_strobe = r_b_strobe;
  assign mem_read_start         = r_mem_read_start;
  assign mem_address            = r_mem_address;
  assign busy                   = r_busy;
  assign grant                  = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_apa102_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apa102_read_arbiter
// Description : Scoreboard bench for apa102_read_arbiter. A memory responder
//               answers each start with a chosen latency and data. A
//               cycle-level reference model predicts grants and deliveries
//               from the request history, and queues the expected strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apa102_read_arbiter;

  localparam int AW = 16;
  localparam int TO = 8;
  localparam int HN = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_read_request = 1'b0;
  logic [AW-1:0] a_read_address = '0;
  logic [15:0]   a_read_data;
  logic          a_read_finished_strobe;
  logic          b_read_request = 1'b0;
  logic [AW-1:0] b_read_address = '0;
  logic [15:0]   b_read_data;
  logic          b_read_finished_strobe;
  logic          mem_read_start;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_read_data = 16'h0000;
  logic          mem_read_done = 1'b0;
  logic          busy;
  logic [1:0]    grant;
  logic          timeout_error;

  apa102_read_arbiter #(.ADDRESS_BUS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .a_read_request(a_read_request), .a_read_address(a_read_address),
    .a_read_data(a_read_data), .a_read_finished_strobe(a_read_finished_strobe),
    .b_read_request(b_read_request), .b_read_address(b_read_address),
    .b_read_data(b_read_data), .b_read_finished_strobe(b_read_finished_strobe),
    .mem_read_start(mem_read_start), .mem_address(mem_address),
    .mem_read_data(mem_read_data), .mem_read_done(mem_read_done),
    .busy(busy), .grant(grant), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int          done_at = -1;
  logic [15:0] pend_data = 16'h0000;
  int          fixed_lat = 0;
  bit          fixed_data_en = 1'b0;
  logic [15:0] fixed_data = 16'h0000;
  bit          mem_mute = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc == done_at) begin
        mem_read_done = 1'b1;
        mem_read_data = pend_data;
      end else begin
        mem_read_done = 1'b0;
        mem_read_data = 16'($urandom);
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          cli;
    logic [15:0] data;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  bit          rst_h[HN];
  bit          ra_h[HN];
  bit          rb_h[HN];
  logic [15:0] aa_h[HN];
  logic [15:0] ab_h[HN];
  bit          done_h[HN];
  logic [15:0] md_h[HN];

  bit          m_busy = 1'b0;
  int          m_last = 1;
  int          m_cli = 0;
  int          m_start = 0;
  int          m_del = -1;
  int          idle_from = 0;
  int          m_del_a = -10;
  int          m_del_b = -10;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] m_dat_a = 16'h0000;
  logic [15:0] m_dat_b = 16'h0000;
  logic [15:0] m_pend = 16'h0000;
  bit          m_pend_to = 1'b0;
  bit          m_to_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        int n;
        bit exp_start;
        int win;
        n = cyc;
        rst_h[n] = rst; ra_h[n] = a_read_request; rb_h[n] = b_read_request;
        aa_h[n] = a_read_address; ab_h[n] = b_read_address;
        done_h[n] = mem_read_done; md_h[n] = mem_read_data;

        if (mem_read_start && !rst && !mem_mute) begin
          done_at   = n + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5)));
          pend_data = fixed_data_en ? fixed_data : 16'($urandom);
        end

        if (rst) begin
          m_busy = 1'b0; m_last = 1; m_del = -1; idle_from = n + 1;
          m_del_a = -10; m_del_b = -10; m_addr = 16'h0000;
          m_dat_a = 16'h0000; m_dat_b = 16'h0000; m_to_err = 1'b0;
          exp_q.delete();
        end else begin
          exp_start = 1'b0;
          win = 0;
          if (!m_busy && n >= 1 && n - 1 >= idle_from) begin
            bit ea, eb;
            ea = ra_h[n-1] && (m_del_a != n - 2);
            eb = rb_h[n-1] && (m_del_b != n - 2);
            if (ea || eb) begin
              exp_start = 1'b1;
              win = (ea && eb) ? ((m_last == 0) ? 1 : 0) : (eb ? 1 : 0);
            end
          end
          chk("mem_read_start", mem_read_start, exp_start);

          if (exp_start) begin
            m_addr = (win == 1) ? ab_h[n-1] : aa_h[n-1];
            m_busy = 1'b1; m_cli = win; m_start = n; m_last = win; m_del = -1;
          end else if (m_busy && m_del < 0 && n > m_start) begin
            if (done_h[n]) begin
              m_del = n + 1; m_pend = md_h[n]; m_pend_to = 1'b0;
              exp_q.push_back('{cli: m_cli, data: md_h[n], at: n + 1});
            end
`ifdef ARB_TIMEOUT_EN
            else if (n == m_start + 1 + TO) begin
              m_del = n + 1; m_pend = 16'hDEAD; m_pend_to = 1'b1;
              exp_q.push_back('{cli: m_cli, data: 16'hDEAD, at: n + 1});
            end
`endif
          end

          if (n == m_del) begin
            if (m_cli == 1) m_dat_b = m_pend; else m_dat_a = m_pend;
            if (m_pend_to) m_to_err = 1'b1;
          end

          chk("busy", busy, m_busy);
          chk("grant", grant, m_busy ? ((m_cli == 1) ? 2'b10 : 2'b01) : 2'b00);
          chk("mem_address", mem_address, m_addr);
          chk("a_read_data", a_read_data, m_dat_a);
          chk("b_read_data", b_read_data, m_dat_b);
          chk("timeout_error", timeout_error, m_to_err);

          if (a_read_finished_strobe || b_read_finished_strobe) begin
            chk("both_strobes", a_read_finished_strobe && b_read_finished_strobe, 1'b0);
            chk("strobe_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              exp_t e;
              e = exp_q.pop_front();
              chk("strobe_client", b_read_finished_strobe ? 1 : 0, e.cli);
              chk("strobe_data", b_read_finished_strobe ? b_read_data : a_read_data, e.data);
              chk("strobe_cycle", n, e.at);
            end
          end

          if (n == m_del) begin
            chk("strobe_due", (m_cli == 1) ? b_read_finished_strobe : a_read_finished_strobe, 1'b1);
            m_busy = 1'b0; idle_from = n + 1; m_del = -1;
            if (m_cli == 1) m_del_b = n; else m_del_a = n;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_start(input int limit, output int t);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (mem_read_start) begin
        t = cyc;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int ok;
    ok = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle_bound", ok, 1);
  endtask

  initial begin
    int t0, ts, tstr, prev_cli, cnt, cnt2, alt_ok;
    logic [15:0] dat, prev_addr;

    // reset state
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", mem_read_start, 1'b0);
    chk("rst_addr", mem_address, 16'h0000);
    chk("rst_a_data", a_read_data, 16'h0000);
    chk("rst_b_data", b_read_data, 16'h0000);
    chk("rst_strobes", {a_read_finished_strobe, b_read_finished_strobe}, 2'b00);
    chk("rst_timeout", timeout_error, 1'b0);
    tick(1);
    rst = 1'b0;

    // single A read, latency 3
    fixed_lat = 3; fixed_data_en = 1'b1; fixed_data = 16'h1234;
    tick(2);
    a_read_address = 16'h0010; a_read_request = 1'b1; t0 = cyc;
    ts = -1; tstr = -1; dat = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_read_start) begin
        ts = cyc;
        chk("t1_addr", mem_address, 16'h0010);
      end
      if (a_read_finished_strobe) begin
        tstr = cyc; dat = a_read_data;
        break;
      end
    end
    chk("t1_start_latency", ts - t0, 1);
    chk("t1_strobe_latency", tstr - t0, 5);
    chk("t1_data", dat, 16'h1234);
    chk("t1_b_data", b_read_data, 16'h0000);
    tick(1);
    a_read_request = 1'b0;

    // both continuous, latency 1: service must alternate
    fixed_lat = 1; fixed_data_en = 1'b0;
    tick(3);
    a_read_address = 16'h0100; b_read_address = 16'h0200;
    a_read_request = 1'b1; b_read_request = 1'b1;
    cnt = 0; prev_cli = -1; alt_ok = 1; prev_addr = 16'hFFFF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_read_start) begin
        chk("t2_addr_changes", mem_address != prev_addr, 1'b1);
        prev_addr = mem_address;
      end
      if (a_read_finished_strobe || b_read_finished_strobe) begin
        if (prev_cli == (b_read_finished_strobe ? 1 : 0)) alt_ok = 0;
        prev_cli = b_read_finished_strobe ? 1 : 0;
        cnt++;
      end
    end
    chk("t2_strobe_count", cnt, 10);
    chk("t2_alternation", alt_ok, 1);
    tick(1);
    a_read_request = 1'b0; b_read_request = 1'b0;
    wait_idle(20);

    // A drops request during WAIT
    fixed_lat = 4;
    tick(2);
    a_read_address = 16'h0333; a_read_request = 1'b1;
    wait_start(10, ts);
    chk("t3_started", ts >= 0, 1'b1);
    tick(1);
    a_read_request = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (a_read_finished_strobe) cnt++;
      if (mem_read_start) cnt2++;
    end
    chk("t3_strobes", cnt, 1);
    chk("t3_restarts", cnt2, 0);

    // reset during WAIT, late completion ignored
    fixed_lat = 6; fixed_data_en = 1'b1; fixed_data = 16'hBEEF;
    tick(1);
    a_read_address = 16'h0444; a_read_request = 1'b1;
    wait_start(10, ts);
    chk("t4_started", ts >= 0, 1'b1);
    tick(2);
    rst = 1'b1; a_read_request = 1'b0;
    tick(2);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (a_read_finished_strobe || b_read_finished_strobe) cnt++;
    end
    chk("t4_no_strobe", cnt, 0);
    chk("t4_grant", grant, 2'b00);
    chk("t4_busy", busy, 1'b0);
    fixed_lat = 2; fixed_data = 16'h5A5A;
    tick(1);
    a_read_address = 16'h0045; a_read_request = 1'b1;
    tstr = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (a_read_finished_strobe) begin
        tstr = cyc; dat = a_read_data;
        break;
      end
    end
    chk("t4_recovered", tstr >= 0, 1'b1);
    chk("t4_data", dat, 16'h5A5A);
    tick(1);
    a_read_request = 1'b0;
    wait_idle(20);

    // memory never answers a B read
    mem_mute = 1'b1;
    tick(2);
    b_read_address = 16'h0555; b_read_request = 1'b1;
    wait_start(10, ts);
    chk("t5_started", ts >= 0, 1'b1);
    tick(1);
    b_read_request = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tstr = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b_read_finished_strobe) begin
        tstr = cyc; dat = b_read_data;
        break;
      end
    end
    chk("t5_to_latency", tstr - ts, 10);
    chk("t5_to_data", dat, 16'hDEAD);
    @(negedge clk);
    chk("t5_to_flag", timeout_error, 1'b1);
    mem_mute = 1'b0; fixed_lat = 2; fixed_data = 16'h7777;
    tick(1);
    a_read_address = 16'h0077; a_read_request = 1'b1;
    tstr = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (a_read_finished_strobe) begin
        tstr = cyc; dat = a_read_data;
        break;
      end
    end
    chk("t5_after_data", dat, 16'h7777);
    chk("t5_sticky", timeout_error, 1'b1);
    tick(1);
    a_read_request = 1'b0;
    wait_idle(20);
`else
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (a_read_finished_strobe || b_read_finished_strobe) cnt++;
      if (!busy) cnt2++;
    end
    chk("t5_no_strobe", cnt, 0);
    chk("t5_busy_held", cnt2, 0);
    chk("t5_no_timeout", timeout_error, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0; mem_mute = 1'b0;
`endif

    // randomized traffic
    fixed_lat = 0; fixed_data_en = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick(1);
      if (!a_read_request) begin
        if ($urandom_range(0, 2) == 0) begin
          a_read_request = 1'b1; a_read_address = 16'($urandom);
        end
      end else if ($urandom_range(0, 5) == 0) begin
        a_read_request = 1'b0;
      end
      if (!b_read_request) begin
        if ($urandom_range(0, 2) == 0) begin
          b_read_request = 1'b1; b_read_address = 16'($urandom);
        end
      end else if ($urandom_range(0, 5) == 0) begin
        b_read_request = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) a_read_address = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b_read_address = 16'($urandom);
    end
    tick(1);
    a_read_request = 1'b0; b_read_request = 1'b0;
    wait_idle(20);
    tick(3);
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
